// File: rtl/aes_stream_ctrl_if.sv
// rtl/aes_stream_ctrl_if.sv - job, engine and result handshake bundle for aes_stream_ctrl
interface aes_stream_ctrl_if #(
    parameter int DATA_W = 128,
    parameter int TAG_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic              in_encOrDec;
    logic [2:0]        in_keySize;
    logic [DATA_W-1:0] in_message;
    logic [TAG_W-1:0]  in_tag;

    logic              core_start;
    logic              core_encOrDec;
    logic [2:0]        core_keySize;
    logic [DATA_W-1:0] core_message;
    logic              core_done;
    logic [DATA_W-1:0] core_result;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_message;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    logic              busy;

    modport master (
        output in_valid, in_encOrDec, in_keySize, in_message, in_tag,
        input  in_ready,
        input  core_start, core_encOrDec, core_keySize, core_message,
        output core_done, core_result,
        input  out_valid, out_message, out_tag, out_err,
        output out_ready,
        input  busy
    );

    modport slave (
        input  in_valid, in_encOrDec, in_keySize, in_message, in_tag,
        output in_ready,
        output core_start, core_encOrDec, core_keySize, core_message,
        input  core_done, core_result,
        output out_valid, out_message, out_tag, out_err,
        input  out_ready,
        output busy
    );
endinterface

// File: rtl/aes_stream_ctrl.sv
// rtl/aes_stream_ctrl.sv - queued job controller for the AES round engine
// Optional engine watchdog enabled by defining AES_STREAM_TIMEOUT_EN.
module aes_stream_ctrl #(
    parameter int DATA_W         = 128,
    parameter int DEPTH          = 4,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic              clock,
    input logic              reset,
    aes_stream_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, STORE} state_t;
    state_t state;

    logic [DATA_W-1:0] iq_msg [DEPTH];
    logic [TAG_W-1:0]  iq_tag [DEPTH];
    logic [2:0]        iq_ks  [DEPTH];
    logic              iq_enc [DEPTH];
    logic [AW:0]       iq_wr, iq_rd;
    logic              iq_empty, iq_full, iq_push, iq_pop;

    logic [DATA_W-1:0] oq_msg [DEPTH];
    logic [TAG_W-1:0]  oq_tag [DEPTH];
    logic              oq_err [DEPTH];
    logic [AW:0]       oq_wr, oq_rd;
    logic              oq_empty, oq_full, oq_push, oq_pop;

    logic [DATA_W-1:0] job_msg, res_msg;
    logic [TAG_W-1:0]  job_tag;
    logic [2:0]        job_ks;
    logic              job_enc, res_err, start_q;

`ifdef AES_STREAM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] timer;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    function automatic logic ks_legal(input logic [2:0] ks);
        return (ks == 3'b001) || (ks == 3'b010) || (ks == 3'b100);
    endfunction

    // Full when the pointers differ only in the wrap bit.
    assign iq_empty = (iq_wr == iq_rd);
    assign iq_full  = (iq_wr[AW] != iq_rd[AW]) && (iq_wr[AW-1:0] == iq_rd[AW-1:0]);
    assign oq_empty = (oq_wr == oq_rd);
    assign oq_full  = (oq_wr[AW] != oq_rd[AW]) && (oq_wr[AW-1:0] == oq_rd[AW-1:0]);

    // Only one job is ever in flight, so a free output slot at launch is the reservation.
    assign iq_push = bus.in_valid && !iq_full;
    assign iq_pop  = (state == IDLE) && !iq_empty && !oq_full;
    assign oq_push = (state == STORE);
    assign oq_pop  = !oq_empty && bus.out_ready;

    assign bus.in_ready      = !iq_full;
    assign bus.core_start    = start_q;
    assign bus.core_encOrDec = job_enc;
    assign bus.core_keySize  = job_ks;
    assign bus.core_message  = job_msg;
    assign bus.out_valid     = !oq_empty;
    assign bus.out_message   = oq_empty ? '0 : oq_msg[oq_rd[AW-1:0]];
    assign bus.out_tag       = oq_empty ? '0 : oq_tag[oq_rd[AW-1:0]];
    assign bus.out_err       = !oq_empty && oq_err[oq_rd[AW-1:0]];
    assign bus.busy          = (state != IDLE) || !iq_empty || !oq_empty;

    always_ff @(posedge clock) begin
        if (iq_push) begin
            iq_msg[iq_wr[AW-1:0]] <= bus.in_message;
            iq_tag[iq_wr[AW-1:0]] <= bus.in_tag;
            iq_ks[iq_wr[AW-1:0]]  <= bus.in_keySize;
            iq_enc[iq_wr[AW-1:0]] <= bus.in_encOrDec;
        end
        if (oq_push) begin
            oq_msg[oq_wr[AW-1:0]] <= res_msg;
            oq_tag[oq_wr[AW-1:0]] <= job_tag;
            oq_err[oq_wr[AW-1:0]] <= res_err;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            iq_wr <= '0;
            iq_rd <= '0;
            oq_wr <= '0;
            oq_rd <= '0;
        end else begin
            if (iq_push) iq_wr <= iq_wr + 1'b1;
            if (iq_pop)  iq_rd <= iq_rd + 1'b1;
            if (oq_push) oq_wr <= oq_wr + 1'b1;
            if (oq_pop)  oq_rd <= oq_rd + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
            job_msg <= '0;
            job_tag <= '0;
            job_ks  <= '0;
            job_enc <= 1'b0;
            res_msg <= '0;
            res_err <= 1'b0;
`ifdef AES_STREAM_TIMEOUT_EN
            timer   <= '0;
`endif
        end else begin
            start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (iq_pop) begin
                        job_msg <= iq_msg[iq_rd[AW-1:0]];
                        job_tag <= iq_tag[iq_rd[AW-1:0]];
                        job_ks  <= iq_ks[iq_rd[AW-1:0]];
                        job_enc <= iq_enc[iq_rd[AW-1:0]];
                        start_q <= ks_legal(iq_ks[iq_rd[AW-1:0]]);
                        state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
`ifdef AES_STREAM_TIMEOUT_EN
                    timer <= '0;
`endif
                    if (ks_legal(job_ks)) begin
                        state <= WAIT;
                    end else begin
                        res_msg <= '0;
                        res_err <= 1'b1;
                        state   <= STORE;
                    end
                end
                WAIT: begin
                    if (bus.core_done) begin
                        res_msg <= bus.core_result;
                        res_err <= 1'b0;
                        state   <= STORE;
                    end
`ifdef AES_STREAM_TIMEOUT_EN
                    else if (timer == TIMER_LAST) begin
                        res_msg <= '0;
                        res_err <= 1'b1;
                        state   <= STORE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end
                STORE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb/tb_aes_stream_ctrl.sv - self-checking bench for aes_stream_ctrl with engine model and scoreboard
module tb_aes_stream_ctrl;
    localparam int DATA_W = 128;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 4;
    localparam int TMO    = 16;
    localparam logic [127:0] AES_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] AES_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct packed {
        logic [127:0] msg;
        logic [3:0]   tag;
        logic         err;
    } res_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   starts = 0;
    int   done_cyc = 0;
    int   eng_lat = 0;
    int   ready_mode = 0;
    bit   expect_abort = 1'b0;
    res_t exp_q[$];
    res_t got_exp;

    aes_stream_ctrl_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    aes_stream_ctrl #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (bus.core_start === 1'b1) starts <= starts + 1;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Stand-in for the AES engine: known vector plus a cheap keyed permutation.
    function automatic logic [127:0] eng_fn(input logic [127:0] m, input logic e, input logic [2:0] k);
        if (m == AES_PT && e && k == 3'b001) return AES_CT;
        if (e) return {m[95:0], m[127:96]} ^ {32'ha5a5_0000, 93'b0, k};
        return ~m ^ {125'b0, k};
    endfunction

    function automatic logic [2:0] legal_ks();
        case ($urandom_range(0, 2))
            0:       return 3'b001;
            1:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [127:0] rand_msg();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin : engine
        logic [127:0] m;
        logic         e;
        logic [2:0]   k;
        int           lat;
        bus.core_done   = 1'b0;
        bus.core_result = '0;
        forever begin
            @(negedge clock);
            if (bus.core_start === 1'b1) begin
                m = bus.core_message;
                e = bus.core_encOrDec;
                k = bus.core_keySize;
                lat = (eng_lat != 0) ? eng_lat : int'($urandom_range(1, 6));
                repeat (lat) @(negedge clock);
                bus.core_done   = 1'b1;
                bus.core_result = eng_fn(m, e, k);
                done_cyc = cyc;
                @(negedge clock);
                bus.core_done   = 1'b0;
                bus.core_result = '0;
            end
        end
    end

    initial begin : sink
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clock);
            bus.out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
        end
    end

    always @(negedge clock) begin
        #2;
        if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            compared++;
            assert (exp_q.size() != 0) else begin
                mismatched++;
                $error("FAIL unexpected_output observed=tag %0d expected=no output", bus.out_tag);
            end
            if (exp_q.size() != 0) begin
                got_exp = exp_q.pop_front();
                chk("out_message", bus.out_message, got_exp.msg);
                chk("out_tag", 128'(bus.out_tag), 128'(got_exp.tag));
                chk("out_err", 128'(bus.out_err), 128'(got_exp.err));
            end
        end
    end

    // Reference: error iff keySize not one-hot (or watchdog abort); results in input order.
    task automatic push_job(input logic [127:0] m, input logic e, input logic [2:0] k, input logic [3:0] t);
        int   n = 0;
        res_t r;
        bus.in_valid    = 1'b1;
        bus.in_message  = m;
        bus.in_encOrDec = e;
        bus.in_keySize  = k;
        bus.in_tag      = t;
        while (bus.in_ready !== 1'b1 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("push_accept", 128'(bus.in_ready), 128'(1));
        r.err = ($countones(k) != 1) || expect_abort;
        r.msg = r.err ? '0 : eng_fn(m, e, k);
        r.tag = t;
        if (bus.in_ready === 1'b1) exp_q.push_back(r);
        @(negedge clock);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy !== 1'b0) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk("drain_in_time", 128'(n < 3000), 128'(1));
    endtask

    task automatic wait_start();
        int n = 0;
        while (bus.core_start !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("start_seen", 128'(bus.core_start), 128'(1));
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench stalled");
    end

    initial begin : main
        int n;
        int s0;
        bus.in_valid    = 1'b0;
        bus.in_encOrDec = 1'b0;
        bus.in_keySize  = '0;
        bus.in_message  = '0;
        bus.in_tag      = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_core_start", 128'(bus.core_start), 128'(0));
        chk("rst_core_message", bus.core_message, 128'(0));
        chk("rst_core_keySize", 128'(bus.core_keySize), 128'(0));
        chk("rst_core_encOrDec", 128'(bus.core_encOrDec), 128'(0));
        chk("rst_out_message", bus.out_message, 128'(0));
        chk("rst_out_tag", 128'(bus.out_tag), 128'(0));
        chk("rst_out_err", 128'(bus.out_err), 128'(0));

        // Known-answer job, fixed 10-cycle engine.
        ready_mode = 1;
        eng_lat = 10;
        s0 = starts;
        push_job(AES_PT, 1'b1, 3'b001, 4'd3);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("t1_out_valid", 128'(bus.out_valid), 128'(1));
        chk("t1_done_to_valid", 128'(cyc - done_cyc), 128'(2));
        chk("t1_out_message", bus.out_message, AES_CT);
        chk("t1_out_tag", 128'(bus.out_tag), 128'(3));
        chk("t1_out_err", 128'(bus.out_err), 128'(0));
        wait_drain();
        chk("t1_start_pulses", 128'(starts - s0), 128'(1));

        // Fill both queues with the sink stalled, then release.
        ready_mode = 0;
        eng_lat = 0;
        for (int i = 0; i < 2 * DEPTH; i++) push_job(rand_msg(), 1'($urandom_range(0, 1)), legal_ks(), 4'(i));
        bus.in_message = rand_msg();
        bus.in_tag     = 4'd8;
        repeat (60) @(negedge clock);
        chk("fill_in_ready", 128'(bus.in_ready), 128'(0));
        chk("fill_out_valid", 128'(bus.out_valid), 128'(1));
        chk("fill_busy", 128'(bus.busy), 128'(1));
        ready_mode = 1;
        push_job(bus.in_message, 1'b0, 3'b010, 4'd8);
        bus.in_valid = 1'b0;
        wait_drain();

        // Illegal key size sandwiched between legal jobs.
        s0 = starts;
        push_job(rand_msg(), 1'b1, 3'b100, 4'd1);
        push_job(rand_msg(), 1'b1, 3'b011, 4'd5);
        push_job(rand_msg(), 1'b0, 3'b001, 4'd6);
        bus.in_valid = 1'b0;
        wait_drain();
        chk("illegal_start_pulses", 128'(starts - s0), 128'(2));

        // Reset while the engine is busy; its done pulse lands afterwards.
        eng_lat = 5;
        push_job(rand_msg(), 1'b1, 3'b010, 4'd9);
        bus.in_valid = 1'b0;
        wait_start();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("rst_mid_out_valid", 128'(bus.out_valid), 128'(0));
            chk("rst_mid_busy", 128'(bus.busy), 128'(0));
            @(negedge clock);
        end
        eng_lat = 0;
        push_job(rand_msg(), 1'b0, 3'b100, 4'd10);
        push_job(rand_msg(), 1'b1, 3'b001, 4'd11);
        bus.in_valid = 1'b0;
        wait_drain();

        // Random stream with random sink stalls: wraps both queues several times.
        ready_mode = 2;
        for (int i = 0; i < 6 * DEPTH; i++) begin
            logic [2:0] k;
            k = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : legal_ks();
            push_job(rand_msg(), 1'($urandom_range(0, 1)), k, 4'($urandom));
        end
        bus.in_valid = 1'b0;
        ready_mode = 1;
        wait_drain();

        // Engine answers only after 25 cycles.
        eng_lat = 25;
`ifdef AES_STREAM_TIMEOUT_EN
        expect_abort = 1'b1;
`endif
        push_job(rand_msg(), 1'b1, 3'b001, 4'd12);
        bus.in_valid = 1'b0;
        expect_abort = 1'b0;
        wait_start();
`ifdef AES_STREAM_TIMEOUT_EN
        repeat (17) @(negedge clock);
        chk("tmo_store_valid", 128'(bus.out_valid), 128'(0));
        @(negedge clock);
        chk("tmo_out_valid", 128'(bus.out_valid), 128'(1));
        chk("tmo_out_err", 128'(bus.out_err), 128'(1));
        chk("tmo_out_message", bus.out_message, 128'(0));
        wait_drain();
        repeat (30) @(negedge clock);
        chk("tmo_late_done_valid", 128'(bus.out_valid), 128'(0));
        chk("tmo_late_done_busy", 128'(bus.busy), 128'(0));
`else
        repeat (20) @(negedge clock);
        chk("nowd_wait_valid", 128'(bus.out_valid), 128'(0));
        chk("nowd_wait_busy", 128'(bus.busy), 128'(1));
        wait_drain();
`endif
        eng_lat = 0;
        repeat (5) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
